// File: rtl/apb_req_master.sv
// rtl/apb_req_master.sv - single-outstanding APB4 initiator behind a valid/ready request/response pair
module apb_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int STRB_WIDTH    = (DATA_WIDTH + 7) / 8
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    input  logic [2:0]            req_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_slverr_o,
    output logic                  rsp_timeout_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [2:0]            pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort fires on the edge that closes the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  req_ready_n, rsp_valid_n, rsp_slverr_n, rsp_timeout_n;
    logic                  psel_n, penable_n, pwrite_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n, pwdata_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [2:0]            pprot_n;
    logic [STRB_WIDTH-1:0] pstrb_n;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        req_ready_n   = req_ready_o;
        rsp_valid_n   = rsp_valid_o;
        rsp_rdata_n   = rsp_rdata_o;
        rsp_slverr_n  = rsp_slverr_o;
        rsp_timeout_n = rsp_timeout_o;
        psel_n        = psel_o;
        penable_n     = penable_o;
        pwrite_n      = pwrite_o;
        paddr_n       = paddr_o;
        pprot_n       = pprot_o;
        pwdata_n      = pwdata_o;
        pstrb_n       = pstrb_o;
        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid_i && req_ready_o) begin
                    state_n     = SETUP;
                    req_ready_n = 1'b0;
                    psel_n      = 1'b1;
                    paddr_n     = req_addr_i;
                    pwrite_n    = req_write_i;
                    pprot_n     = req_prot_i;
                    pwdata_n    = req_write_i ? req_wdata_i : '0;
                    pstrb_n     = req_write_i ? req_strb_i : '0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = '0;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_n       = RESP;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = pwrite_o ? '0 : prdata_i;
                    rsp_slverr_n  = pslverr_i;
                    rsp_timeout_n = 1'b0;
                end else if (TIMEOUT_CYCLES > 0 && cnt == CNT_LAST) begin
                    state_n       = RESP;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_rdata_n   = '0;
                    rsp_slverr_n  = 1'b1;
                    rsp_timeout_n = 1'b1;
                    cnt_n         = CNT_MAX;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!preset_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            req_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_slverr_o  <= 1'b0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pprot_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            req_ready_o   <= req_ready_n;
            rsp_valid_o   <= rsp_valid_n;
            rsp_rdata_o   <= rsp_rdata_n;
            rsp_slverr_o  <= rsp_slverr_n;
            rsp_timeout_o <= rsp_timeout_n;
            busy_o        <= (state_n != IDLE);
            psel_o        <= psel_n;
            penable_o     <= penable_n;
            pwrite_o      <= pwrite_n;
            paddr_o       <= paddr_n;
            pprot_o       <= pprot_n;
            pwdata_o      <= pwdata_n;
            pstrb_o       <= pstrb_n;
        end
    end

endmodule
